// File: rtl/iobm_ctl_if.sv
// rtl/iobm_ctl_if.sv - Mac I/O bus terminations, strobes and bridge handshake for iobm_ctl
// master is the bridge/bus side, slave is the controller.
interface iobm_ctl_if;
   logic C8M;
   logic E;
   logic nDTACK;
   logic nVPA;
   logic nBERR;
   logic IOREQ;
   logic IORW;
   logic IOL;
   logic IOU;
   logic IOACT;
   logic IOBERR;
   logic nASout;
   logic nLDSout;
   logic nUDSout;
   logic nVMAout;
   logic nDoutOE;

   modport master (
      output C8M, E, nDTACK, nVPA, nBERR, IOREQ, IORW, IOL, IOU,
      input  IOACT, IOBERR, nASout, nLDSout, nUDSout, nVMAout, nDoutOE
   );

   modport slave (
      input  C8M, E, nDTACK, nVPA, nBERR, IOREQ, IORW, IOL, IOU,
      output IOACT, IOBERR, nASout, nLDSout, nUDSout, nVMAout, nDoutOE
   );
endinterface

// File: rtl/iobm_ctl.sv
// rtl/iobm_ctl.sv - I/O bus master: runs one 68000-style asynchronous bus cycle per bridge request
// Terminates on DTACK, VPA (E-clock cycle), BERR or timeout; status returned on IOACT/IOBERR.
module iobm_ctl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic      CLK,
   input  logic      nRST,
   iobm_ctl_if.slave bus
);
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_S2    = 3'd1;
   localparam logic [2:0] ST_S3    = 3'd2;
   localparam logic [2:0] ST_S4    = 3'd3;
   localparam logic [2:0] ST_EWAIT = 3'd4;
   localparam logic [2:0] ST_S5    = 3'd5;
   localparam logic [2:0] ST_S6    = 3'd6;
   localparam logic [2:0] ST_S7    = 3'd7;
   localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

   logic [2:0] r_state;
   logic [2:0] w_next;
   logic [1:0] r_dtack_s;
   logic [1:0] r_vpa_s;
   logic [1:0] r_berr_s;
   logic [1:0] r_e_s;
   logic       r_e_d;
   logic       r_c8m;
   logic       r_rw;
   logic       r_l;
   logic       r_u;
   logic       r_err;
   logic       r_ioberr;
   logic       r_nvma;
   logic [7:0] r_cnt;
   logic       w_dtack;
   logic       w_vpa;
   logic       w_berr;
   logic       w_e;
   logic       w_e_fall;
   logic       w_timeout;
   logic       w_set_err;
   logic       w_as;
   logic       w_ds;
   logic       w_oe;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_dtack_s <= 2'b11;
         r_vpa_s   <= 2'b11;
         r_berr_s  <= 2'b11;
         r_e_s     <= 2'b00;
         r_e_d     <= 1'b0;
         r_c8m     <= 1'b0;
      end else begin
         r_dtack_s <= {r_dtack_s[0], bus.nDTACK};
         r_vpa_s   <= {r_vpa_s[0], bus.nVPA};
         r_berr_s  <= {r_berr_s[0], bus.nBERR};
         r_e_s     <= {r_e_s[0], bus.E};
         r_e_d     <= r_e_s[1];
         r_c8m     <= bus.C8M;
      end
   end

   assign w_dtack   = !r_dtack_s[1];
   assign w_vpa     = !r_vpa_s[1];
   assign w_berr    = !r_berr_s[1];
   assign w_e       = r_e_s[1];
   assign w_e_fall  = r_e_d && !w_e;
   assign w_timeout = (r_cnt >= TIMEOUT_CNT);

   // Acceptance uses live C8M, termination the previous sample: S4 then lands on
   // the exit phase, so an already-asserted DTACK ends the cycle on its first S4 clock.
   always_comb begin
      w_next    = r_state;
      w_set_err = 1'b0;
      case (r_state)
         ST_IDLE:  if (bus.IOREQ && bus.C8M) w_next = ST_S2;
         ST_S2:    w_next = ST_S3;
         ST_S3:    w_next = ST_S4;
         ST_S4: begin
            if (r_c8m) begin
               if (w_berr) begin
                  w_next    = ST_S5;
                  w_set_err = 1'b1;
               end else if (w_dtack) begin
                  w_next = ST_S5;
               end else if (w_vpa) begin
                  w_next = ST_EWAIT;
               end else if (w_timeout) begin
                  w_next    = ST_S5;
                  w_set_err = 1'b1;
               end
            end
         end
         ST_EWAIT: begin
            if (w_berr || w_timeout) begin
               w_next    = ST_S5;
               w_set_err = 1'b1;
            end else if (!r_nvma && w_e_fall) begin
               w_next = ST_S5;
            end
         end
         ST_S5:    w_next = ST_S6;
         ST_S6:    w_next = ST_S7;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 8'd0;
         r_rw     <= 1'b1;
         r_l      <= 1'b0;
         r_u      <= 1'b0;
         r_err    <= 1'b0;
         r_ioberr <= 1'b0;
         r_nvma   <= 1'b1;
      end else begin
         r_state <= w_next;
         if (r_state == ST_IDLE && w_next == ST_S2) begin
            r_rw     <= bus.IORW;
            r_l      <= bus.IOL;
            r_u      <= bus.IOU;
            r_err    <= 1'b0;
            r_ioberr <= 1'b0;
            r_cnt    <= 8'd0;
         end
         // Saturate so the timeout cannot be skipped by wrapping on the wrong C8M phase.
         if ((r_state == ST_S4 || r_state == ST_EWAIT) && r_cnt != 8'hFF)
            r_cnt <= r_cnt + 8'd1;
         if (w_set_err)
            r_err <= 1'b1;
         if (r_state == ST_EWAIT && !w_e)
            r_nvma <= 1'b0;
         if (r_state == ST_S6) begin
            r_nvma   <= 1'b1;
            r_ioberr <= r_err;
         end
      end
   end

   assign w_as = (r_state == ST_S2) || (r_state == ST_S3) || (r_state == ST_S4) ||
                 (r_state == ST_EWAIT) || (r_state == ST_S5) || (r_state == ST_S6);
   assign w_ds = r_rw ? w_as : (w_as && r_state != ST_S2 && r_state != ST_S3);
   assign w_oe = !r_rw && (r_state != ST_IDLE) && (r_state != ST_S2);

   assign bus.IOACT   = (r_state != ST_IDLE);
   assign bus.IOBERR  = r_ioberr;
   assign bus.nASout  = !w_as;
   assign bus.nLDSout = !(w_ds && r_l);
   assign bus.nUDSout = !(w_ds && r_u);
   assign bus.nVMAout = r_nvma;
   assign bus.nDoutOE = !w_oe;
endmodule

// File: tb/tb_iobm_ctl.sv
// tb/tb_iobm_ctl.sv - directed self-checking bench for iobm_ctl
module tb_iobm_ctl;
   logic CLK = 1'b0;
   logic nRST = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   logic log_as [8];
   logic log_lds[8];
   logic log_uds[8];
   logic log_oe [8];
   logic log_vma[8];
   logic log_berr[8];
   logic oe_low, vma_low, idle_oe, idle_berr, idle_vma, berr_pre;
   int   len, e_n;

   iobm_ctl_if bus();

   iobm_ctl #(.TIMEOUT(255)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   always #31 CLK = ~CLK;

   initial begin
      bus.C8M = 1'b0;
      forever begin
         @(posedge CLK);
         #1 bus.C8M = ~bus.C8M;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic run_xfer(input logic rw, input logic l, input logic u, output int n);
      int guard;
      @(posedge CLK);
      #1;
      bus.IORW  = rw;
      bus.IOL   = l;
      bus.IOU   = u;
      bus.IOREQ = 1'b1;
      guard     = 0;
      berr_pre  = bus.IOBERR;
      @(negedge CLK);
      while (!bus.IOACT && guard < 10) begin
         berr_pre = bus.IOBERR;
         guard++;
         @(negedge CLK);
      end
      check("accept", int'(bus.IOACT), 1);
      bus.IOREQ = 1'b0;
      n       = 0;
      oe_low  = 1'b0;
      vma_low = 1'b0;
      while (bus.IOACT && n < 400) begin
         if (n < 8) begin
            log_as[n]   = bus.nASout;
            log_lds[n]  = bus.nLDSout;
            log_uds[n]  = bus.nUDSout;
            log_oe[n]   = bus.nDoutOE;
            log_vma[n]  = bus.nVMAout;
            log_berr[n] = bus.IOBERR;
         end
         if (!bus.nDoutOE) oe_low = 1'b1;
         if (!bus.nVMAout) vma_low = 1'b1;
         n++;
         @(negedge CLK);
      end
      idle_oe   = bus.nDoutOE;
      idle_berr = bus.IOBERR;
      idle_vma  = bus.nVMAout;
   endtask

   task automatic drive_dtack_late();
      int g = 0;
      while (bus.nASout && g < 20) begin
         @(negedge CLK);
         g++;
      end
      repeat (2) @(posedge CLK);
      #1 bus.nDTACK = 1'b0;
   endtask

   task automatic drive_e(output int n);
      int g = 0;
      n = 0;
      while (bus.nVMAout && g < 100) begin
         @(negedge CLK);
         g++;
      end
      @(posedge CLK);
      #1 bus.E = 1'b1;
      repeat (8) @(posedge CLK);
      #1 bus.E = 1'b0;
      while (bus.IOACT && n < 50) begin
         @(negedge CLK);
         n++;
      end
   endtask

   initial begin
      bus.E = 1'b0;
      bus.nDTACK = 1'b1;
      bus.nVPA = 1'b1;
      bus.nBERR = 1'b1;
      bus.IOREQ = 1'b0;
      bus.IORW = 1'b1;
      bus.IOL = 1'b0;
      bus.IOU = 1'b0;

      repeat (4) @(posedge CLK);
      @(negedge CLK);
      check("rst_nas", int'(bus.nASout), 1);
      check("rst_nlds", int'(bus.nLDSout), 1);
      check("rst_nuds", int'(bus.nUDSout), 1);
      check("rst_nvma", int'(bus.nVMAout), 1);
      check("rst_noe", int'(bus.nDoutOE), 1);
      check("rst_ioact", int'(bus.IOACT), 0);
      check("rst_ioberr", int'(bus.IOBERR), 0);
      @(posedge CLK);
      #1 nRST = 1'b1;
      repeat (3) @(posedge CLK);

      // read, lower byte, DTACK arrives during S4
      fork
         run_xfer(1'b1, 1'b1, 1'b0, len);
         drive_dtack_late();
      join
      check("rd_len", len, 8);
      check("rd_nas_s2", int'(log_as[0]), 0);
      check("rd_nlds_s2", int'(log_lds[0]), 0);
      check("rd_nuds_s2", int'(log_uds[0]), 1);
      check("rd_oe_never", int'(oe_low), 0);
      check("rd_ioberr", int'(idle_berr), 0);
      bus.nDTACK = 1'b1;
      repeat (3) @(posedge CLK);

      // word write, DTACK already low
      bus.nDTACK = 1'b0;
      run_xfer(1'b0, 1'b1, 1'b1, len);
      check("wr_len", len, 6);
      check("wr_noe_s2", int'(log_oe[0]), 1);
      check("wr_noe_s3", int'(log_oe[1]), 0);
      check("wr_nlds_s3", int'(log_lds[1]), 1);
      check("wr_nlds_s4", int'(log_lds[2]), 0);
      check("wr_nuds_s4", int'(log_uds[2]), 0);
      check("wr_noe_idle", int'(idle_oe), 1);
      check("wr_ioberr", int'(idle_berr), 0);
      bus.nDTACK = 1'b1;
      repeat (3) @(posedge CLK);

      // VPA read with an E cycle
      bus.nVPA = 1'b0;
      fork
         run_xfer(1'b1, 1'b1, 1'b1, len);
         drive_e(e_n);
      join
      check("vpa_efall_to_idle", e_n, 7);
      check("vpa_nvma_s2", int'(log_vma[0]), 1);
      check("vpa_vma_seen", int'(vma_low), 1);
      check("vpa_nvma_idle", int'(idle_vma), 1);
      check("vpa_ioberr", int'(idle_berr), 0);
      bus.nVPA = 1'b1;
      repeat (3) @(posedge CLK);

      // VPA together with DTACK: no E cycle
      bus.nVPA = 1'b0;
      bus.nDTACK = 1'b0;
      run_xfer(1'b1, 1'b1, 1'b1, len);
      check("vpadt_len", len, 6);
      check("vpadt_no_vma", int'(vma_low), 0);
      bus.nVPA = 1'b1;
      repeat (3) @(posedge CLK);

      // BERR and DTACK together: BERR wins
      bus.nBERR = 1'b0;
      run_xfer(1'b0, 1'b1, 1'b0, len);
      check("berr_len", len, 6);
      check("berr_ioberr", int'(idle_berr), 1);
      bus.nBERR = 1'b1;
      repeat (3) @(posedge CLK);
      run_xfer(1'b1, 1'b1, 1'b1, len);
      check("berr_hold", int'(berr_pre), 1);
      check("berr_clr_s2", int'(log_berr[0]), 0);
      check("berr_next_ok", int'(idle_berr), 0);
      bus.nDTACK = 1'b1;
      repeat (3) @(posedge CLK);

      // no termination: timeout
      run_xfer(1'b1, 1'b0, 1'b1, len);
      check("to_len", len, 262);
      check("to_ioberr", int'(idle_berr), 1);
      repeat (3) @(posedge CLK);

      // reset during S4 of a write
      @(posedge CLK);
      #1;
      bus.IORW = 1'b0;
      bus.IOL = 1'b1;
      bus.IOU = 1'b1;
      bus.IOREQ = 1'b1;
      len = 0;
      @(negedge CLK);
      while (!bus.IOACT && len < 10) begin
         len++;
         @(negedge CLK);
      end
      bus.IOREQ = 1'b0;
      repeat (3) @(negedge CLK);
      check("mid_noe", int'(bus.nDoutOE), 0);
      @(posedge CLK);
      #1 nRST = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      check("mrst_nas", int'(bus.nASout), 1);
      check("mrst_nlds", int'(bus.nLDSout), 1);
      check("mrst_nuds", int'(bus.nUDSout), 1);
      check("mrst_nvma", int'(bus.nVMAout), 1);
      check("mrst_noe", int'(bus.nDoutOE), 1);
      check("mrst_ioact", int'(bus.IOACT), 0);
      check("mrst_ioberr", int'(bus.IOBERR), 0);
      @(posedge CLK);
      #1 nRST = 1'b1;
      bus.nDTACK = 1'b0;
      repeat (2) @(posedge CLK);
      run_xfer(1'b0, 1'b1, 1'b1, len);
      check("post_rst_len", len, 6);
      check("post_rst_ioberr", int'(idle_berr), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/iobm_ctl.md
# iobm_ctl

I/O bus master controller: the responder end of the IOREQ/IOACT/IOBERR handshake raised by the FSB-side I/O bridge. It accepts one latched transfer at a time from the FIFO primary level and runs a 68000-style asynchronous bus cycle on the Mac I/O bus. The cycle ends on /DTACK, on /VPA as a 6800 E-clock cycle, on /BERR, or on an internal timeout. Completion status is returned on IOACT/IOBERR.

## Interface
Parameters:
- TIMEOUT, 255: CLK cycles allowed in S4/EWAIT before forced bus-error termination (8-bit counter).

Ports:
- CLK  in  1  16 MHz clock; C8M is derived from it and phase-aligned.
- nRST  in  1  reset; synchronous, active-low.
- C8M  in  1  8 MHz I/O bus clock, synchronous to CLK; alternates 1/0 on successive CLK samples.
- E  in  1  6800 E clock, asynchronous.
- nDTACK, nVPA, nBERR  in  1 each  I/O bus terminations, asynchronous, active-low.
- IOREQ  in  1  transfer request from the bridge.
- IORW  in  1  1 = read, from the FIFO primary level.
- IOL, IOU  in  1 each  lower/upper byte enables, from the FIFO primary level.
- IOACT  out  1  cycle in progress.
- IOBERR  out  1  status of the last cycle; 1 = bus error.
- nASout, nLDSout, nUDSout  out  1 each  I/O bus strobes.
- nVMAout  out  1  6800 valid memory address.
- nDoutOE  out  1  I/O bus write data drive enable.

## Operation
- nDTACK, nVPA, nBERR and E each pass through a 2-flop synchronizer. Active-low synchronizers reset to 1; E resets to 0. C8M is sampled directly.
- IDLE
  - All strobes, nVMAout and nDoutOE are 1; IOACT=0.
  - Go to S2 when IOREQ=1 and sampled C8M=1.
  - On that transition, latch IORW/IOL/IOU into internal registers, clear IOBERR and clear the timeout counter.
- S2
  - nASout=0 and IOACT=1.
  - On a read, nLDSout=!IOL and nUDSout=!IOU.
  - Go to S3.
- S3: on a write, nDoutOE=0. Go to S4.
- S4
  - On a write, assert the strobes per IOL/IOU.
  - Increment the counter each cycle.
  - Exit only on a cycle with sampled C8M=1. Priority at exit:
    - synced BERR=0: S5, set error flag.
    - else synced DTACK=0: S5.
    - else synced VPA=0: go to EWAIT.
    - else counter ≥ TIMEOUT: S5, set error flag.
  - Otherwise stay in S4.
- EWAIT
  - Assert nVMAout=0 once synced E=0 is seen.
  - When synced E goes 1→0 with VMA asserted, go to S5.
  - Synced BERR=0 or timeout at any time: S5 with error.
  - The counter continues to run.
- S5 → S6 → S7, one CLK each; strobes held through S6.
- S7
  - nASout, nLDSout, nUDSout and nVMAout return to 1.
  - IOBERR takes the error flag; IOACT stays 1.
  - Go to IDLE.
- On IDLE entry: IOACT=0 and nDoutOE=1. IOBERR holds its value until the next S2 entry.
- Latched IORW/IOL/IOU are used for the whole cycle. IOREQ changes after acceptance are ignored.

## Timing
- Reset (nRST=0 at a CLK edge), from any state, mid-cycle included:
  - state IDLE;
  - nASout=nLDSout=nUDSout=nVMAout=nDoutOE=1;
  - IOACT=0, IOBERR=0, counter=0.
- Acceptance latency: 1–2 CLK from IOREQ=1, depending on C8M phase. IOACT rises the cycle after acceptance.
- The minimum cycle is S2, S3, S4, S5, S6, S7: 6 CLK of IOACT=1 when DTACK is already low. Synchronizer latency adds 2–3 CLK when DTACK arrives during S4.
- IOBERR is valid no later than the cycle IOACT falls and is stable while IOACT=0.
- At least one IDLE CLK separates cycles, even if IOREQ is still high. The requester withdraws IOREQ on seeing IOACT.
- DTACK and BERR sampled low in the same cycle: BERR wins.
- VPA together with DTACK: DTACK wins, and no E cycle is run.

## Test plan
- Read, IOL=1, IOU=0; DTACK low 3 CLK after nASout falls → nLDSout=0 and nUDSout=1 from S2; IOACT high 8–9 CLK; IOBERR=0; nDoutOE stays 1.
- Write, IOL=IOU=1, DTACK held low → nDoutOE=0 from S3; both strobes low from S4; IOACT high exactly 6 CLK; nDoutOE=1 on the IDLE cycle.
- VPA read with E at 6 low / 4 high C8M periods → nVMAout falls after synced E=0; S5 follows the synced E falling edge; IOBERR=0.
- BERR and DTACK both low in the same S4 → IOBERR=1 when IOACT falls; IOBERR holds 1 until the next S2, then clears.
- No termination with TIMEOUT=255 → exit to S5 on the first C8M=1 cycle with counter ≥255; IOBERR=1.
- nRST=0 during S4 of a write → next CLK: all strobes, nVMAout and nDoutOE =1, IOACT=0, IOBERR=0. A new IOREQ after reset release is accepted normally.
